stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Parametrised stopwatch controller: the mode FSM and the count register it drives, in one block.
- Modes: idle, stop, count-up, count-down, add-step.
- Bounded count range with selectable wrap or saturate at the bounds.
- Advances only on a one-cycle tick enable from the prescaler.
- Output feeds the display/decoder path; the 2-bit mode code keeps the existing encoding.

Parameters:
MAX_VAL, 99, largest count value; count range 0..MAX_VAL.
STEP, 5, amount added on each entry to ADD; legal range 1..MAX_VAL.
CNT_W, $clog2(MAX_VAL+1), count width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
r  in  1  reset, asynchronous, active-high.
clr  in  1  synchronous clear: go to IDLE, count=0.
tick  in  1  count enable, one-cycle pulse.
s  in  1  run (1) / stop (0).
l  in  1  add request; has priority over s.
m  in  1  direction: 1 = up, 0 = down.
count  out  CNT_W  current count value.
q  out  2  mode code: UP=2'b10, DOWN=2'b00, STOP=2'b11, IDLE/ADD=2'b01.
at_zero  out  1  count==0.
at_max  out  1  count==MAX_VAL.

Behaviour:
- Reset: r=1 asynchronously forces state=IDLE, count=0. Outputs then read q=01, at_zero=1, at_max=0.
- Command priority, evaluated every cycle: r > clr > l > s.
- States and transitions, all registered:
  - IDLE, STOP, UP, DOWN: l=1 -> ADD.
  - Otherwise s=1 -> UP if m=1, DOWN if m=0.
  - Otherwise s=0 -> STOP. From IDLE with s=0, state also goes to STOP.
  - ADD with l=1: stay in ADD.
  - ADD with l=0: s=1 -> UP/DOWN by m; s=0 -> STOP.
  - clr=1 in any state: IDLE, count=0, same edge.
  - m is sampled every cycle in UP/DOWN. With s=1 and l=0, toggling m switches directly between UP and DOWN.
- Count update rules:
  - Count changes on tick only when state_reg is UP or DOWN. The decision uses the current state, not the next state.
  - UP: count+1. DOWN: count-1.
  - ADD: count+STEP is applied once, on the edge where state_next==ADD and state_reg!=ADD. Holding l adds nothing further; l must drop, or the state must leave ADD, before the next add.
  - A tick on the same edge as the entry into ADD is ignored; the add wins. A tick in IDLE, STOP or ADD is ignored.
- Arithmetic: compute with CNT_W+1 bits. Wrap results modulo MAX_VAL+1 (see Optional Feature).
  - Wrap examples: up from MAX_VAL -> 0; down from 0 -> MAX_VAL; add gives (count+STEP)-(MAX_VAL+1) when count+STEP > MAX_VAL.
- at_zero and at_max are combinational from count.
- q is combinational from state_reg.
- Unreachable state encodings go to IDLE on the next edge.

Optional Feature:
Macro: STOPWATCH_SATURATE_EN.
- Defined: count clamps at the bounds.
  - UP at MAX_VAL on tick: count stays MAX_VAL and the state goes to STOP.
  - DOWN at 0 on tick: count stays 0 and the state goes to STOP.
  - Add: count = min(count+STEP, MAX_VAL); the state still goes to ADD.
  - Auto-stop has lower priority than clr and l on the same edge.
- Undefined: modulo wrap as described in Behaviour; no auto-stop.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, STOP, UP, DOWN, ADD};
  - mode-code localparams (MODE_UP, MODE_DOWN, MODE_STOP, MODE_IDLE);
  - a function returning the 2-bit code for a state.
- One sub-module, sw_bounded_counter: CNT_W register plus wrap/saturate arithmetic.
  - Inputs: inc, dec, add_en, clr.
  - Outputs: count, hit_bound.
  - The FSM stays in stopwatch_ctrl.

Test Plan:
- Reset: r pulsed mid-count at count=37 -> count=0, q=01 immediately, no clk edge needed; at_zero=1.
- Up wrap (macro off): s=1, m=1, 100 ticks from 0 -> count reaches 99, then 0 on tick 100; q=10 throughout.
- Down saturate (macro on): s=1, m=0 from count=2, 3 ticks -> 1, 0, then 0 with state STOP, q=11.
- Add once: count=10 in STOP, l held 8 cycles with ticks -> count=15 exactly. After l=0 with s=0 -> STOP, count=15. A second l pulse -> 20.
- Add wrap: count=97, l pulse -> 2 with macro off, 99 with macro on.
- Priority: l=1, s=1, clr=0 in UP -> ADD. With clr=1 on the same cycle -> IDLE, count=0. A tick coincident with entry to ADD at count=40 -> count=45, not 46.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state type and 2-bit mode codes for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StStop = 3'd1,
        StUp   = 3'd2,
        StDown = 3'd3,
        StAdd  = 3'd4
    } state_e;

    // Mode codes keep the encoding the display/decoder path already expects.
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b00;
    localparam logic [1:0] MODE_STOP = 2'b11;
    localparam logic [1:0] MODE_IDLE = 2'b01;

    function automatic logic [1:0] mode_code(input state_e st);
        logic [1:0] code;
        case (st)
            StUp:    code = MODE_UP;
            StDown:  code = MODE_DOWN;
            StStop:  code = MODE_STOP;
            default: code = MODE_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sw_bounded_counter.sv
// Bounded 0..MAX_VAL count register with wrap or saturate arithmetic.
// STOPWATCH_SATURATE_EN selects clamping at the bounds instead of modulo wrap.
module sw_bounded_counter #(
    parameter int unsigned MAX_VAL = 99,
    parameter int unsigned STEP    = 5,
    localparam int unsigned CNT_W  = $clog2(MAX_VAL + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             add_en,
    output logic [CNT_W-1:0] count,
    output logic             hit_bound
);

    localparam logic [CNT_W:0] MAX_W  = MAX_VAL[CNT_W:0];
    localparam logic [CNT_W:0] STEP_W = STEP[CNT_W:0];
    localparam logic [CNT_W:0] MOD_W  = MAX_W + 1'b1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W:0]   count_d;
    logic [CNT_W:0]   ext;
    logic [CNT_W:0]   sum_add;
    logic             at_top;
    logic             at_bot;

    always_comb begin
        ext     = {1'b0, count_q};
        sum_add = ext + STEP_W;
        at_top  = (ext == MAX_W);
        at_bot  = (count_q == '0);
        count_d = ext;
        if (clr) begin
            count_d = '0;
        end else if (add_en) begin
            if (sum_add > MAX_W) begin
`ifdef STOPWATCH_SATURATE_EN
                count_d = MAX_W;
`else
                count_d = sum_add - MOD_W;
`endif
            end else begin
                count_d = sum_add;
            end
        end else if (inc) begin
            if (at_top) begin
`ifdef STOPWATCH_SATURATE_EN
                count_d = MAX_W;
`else
                count_d = '0;
`endif
            end else begin
                count_d = ext + 1'b1;
            end
        end else if (dec) begin
            if (at_bot) begin
`ifdef STOPWATCH_SATURATE_EN
                count_d = '0;
`else
                count_d = MAX_W;
`endif
            end else begin
                count_d = ext - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            count_q <= '0;
        end else begin
            count_q <= count_d[CNT_W-1:0];
        end
    end

    assign count     = count_q;
    assign hit_bound = (inc & at_top) | (dec & at_bot);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM driving a bounded count register.
// STOPWATCH_SATURATE_EN: clamp at the bounds and auto-stop instead of wrapping.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_VAL = 99,
    parameter int unsigned STEP    = 5,
    localparam int unsigned CNT_W  = $clog2(MAX_VAL + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             tick,
    input  logic             s,
    input  logic             l,
    input  logic             m,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       q,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [CNT_W:0] MAX_W = MAX_VAL[CNT_W:0];

    state_e state_q, state_d, cmd_state;
    logic   add_entry;
    logic   inc;
    logic   dec;
    logic   hit_bound;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_state is the command-driven target; auto-stop may override it afterwards.
    always_comb begin
        cmd_state = StIdle;
        if (!clr) begin
            case (state_q)
                StIdle, StStop, StUp, StDown, StAdd: begin
                    if (l) begin
                        cmd_state = StAdd;
                    end else if (s) begin
                        cmd_state = m ? StUp : StDown;
                    end else begin
                        cmd_state = StStop;
                    end
                end
                default: cmd_state = StIdle;
            endcase
        end
        add_entry = (cmd_state == StAdd) && (state_q != StAdd);
        inc       = tick && !clr && !add_entry && (state_q == StUp);
        dec       = tick && !clr && !add_entry && (state_q == StDown);
        state_d   = cmd_state;
`ifdef STOPWATCH_SATURATE_EN
        if (hit_bound) begin
            state_d = StStop;
        end
`endif
    end

`ifndef STOPWATCH_SATURATE_EN
    logic unused_hit_bound;
    assign unused_hit_bound = hit_bound;
`endif

    sw_bounded_counter #(
        .MAX_VAL(MAX_VAL),
        .STEP   (STEP)
    ) u_counter (
        .clk      (clk),
        .r        (r),
        .clr      (clr),
        .inc      (inc),
        .dec      (dec),
        .add_en   (add_entry),
        .count    (count),
        .hit_bound(hit_bound)
    );

    always_comb begin
        q       = mode_code(state_q);
        at_zero = (count == '0);
        at_max  = ({1'b0, count} == MAX_W);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed plan steps plus random traffic
// compared every cycle against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

    localparam int MAX_VAL = 99;
    localparam int STEP    = 5;
    localparam int CNT_W   = $clog2(MAX_VAL + 1);
    localparam int NVAL    = MAX_VAL + 1;
`ifdef STOPWATCH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Model modes, named by what the display shows.
    localparam int M_IDLE = 0;
    localparam int M_STOP = 1;
    localparam int M_UP   = 2;
    localparam int M_DOWN = 3;
    localparam int M_ADD  = 4;

    logic             clk = 1'b0;
    logic             r, clr, tick, s, l, m;
    logic [CNT_W-1:0] count;
    logic [1:0]       q;
    logic             at_zero, at_max;

    int vectors     = 0;
    int miscompares = 0;
    int mst         = M_IDLE;
    int mcnt        = 0;

    stopwatch_ctrl #(
        .MAX_VAL(MAX_VAL),
        .STEP   (STEP)
    ) dut (
        .clk    (clk),
        .r      (r),
        .clr    (clr),
        .tick   (tick),
        .s      (s),
        .l      (l),
        .m      (m),
        .count  (count),
        .q      (q),
        .at_zero(at_zero),
        .at_max (at_max)
    );

    always #5 clk = ~clk;

    function automatic int code_of(input int st);
        case (st)
            M_UP:    return 2;
            M_DOWN:  return 0;
            M_STOP:  return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit i_clr, input bit i_tick, input bit i_s, input bit i_l,
                              input bit i_m);
        int  prev;
        bit  entry;
        prev = mst;
        if (i_clr) begin
            mst  = M_IDLE;
            mcnt = 0;
        end else begin
            if (i_l)      mst = M_ADD;
            else if (i_s) mst = i_m ? M_UP : M_DOWN;
            else          mst = M_STOP;
            entry = (mst == M_ADD) && (prev != M_ADD);
            if (entry) begin
                if (SAT) mcnt = (mcnt + STEP > MAX_VAL) ? MAX_VAL : mcnt + STEP;
                else     mcnt = (mcnt + STEP) % NVAL;
            end else if (i_tick && prev == M_UP) begin
                if (SAT && mcnt == MAX_VAL) mst = M_STOP;
                else                        mcnt = (mcnt + 1) % NVAL;
            end else if (i_tick && prev == M_DOWN) begin
                if (SAT && mcnt == 0) mst = M_STOP;
                else                  mcnt = (mcnt + NVAL - 1) % NVAL;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 32'(count), mcnt);
        chk({tag, ".q"}, 32'(q), code_of(mst));
        chk({tag, ".at_zero"}, 32'(at_zero), (mcnt == 0) ? 1 : 0);
        chk({tag, ".at_max"}, 32'(at_max), (mcnt == MAX_VAL) ? 1 : 0);
    endtask

    task automatic cyc(input bit i_clr, input bit i_tick, input bit i_s, input bit i_l,
                       input bit i_m);
        clr  = i_clr;
        tick = i_tick;
        s    = i_s;
        l    = i_l;
        m    = i_m;
        @(posedge clk);
        model_step(i_clr, i_tick, i_s, i_l, i_m);
        #1;
        check_model("model");
    endtask

    // Async reset between edges; outputs must respond with no clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        r = 1'b1;
        #1;
        mst  = M_IDLE;
        mcnt = 0;
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".q"}, 32'(q), 1);
        chk({tag, ".at_zero"}, 32'(at_zero), 1);
        chk({tag, ".at_max"}, 32'(at_max), 0);
        #1;
        r = 1'b0;
    endtask

    task automatic up_to(input int n);
        cyc(0, 0, 1, 0, 1);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 1);
    endtask

    initial begin
        r = 1'b1; clr = 0; tick = 0; s = 0; l = 0; m = 0;
        #12;
        chk("rst.count", 32'(count), 0);
        chk("rst.q", 32'(q), 1);
        chk("rst.at_zero", 32'(at_zero), 1);
        chk("rst.at_max", 32'(at_max), 0);
        r = 1'b0;

        // Reset mid-count at 37.
        up_to(37);
        chk("mid.count37", 32'(count), 37);
        pulse_reset("rst_mid");

        // Up through MAX_VAL.
        up_to(99);
        chk("up.count99", 32'(count), 99);
        chk("up.at_max", 32'(at_max), 1);
        chk("up.q", 32'(q), 2);
        cyc(0, 1, 1, 0, 1);
        chk("up.tick100", 32'(count), SAT ? 99 : 0);
        chk("up.tick100_q", 32'(q), SAT ? 3 : 2);
        pulse_reset("rst_a");

        // Down through zero from 2.
        up_to(2);
        cyc(0, 0, 1, 0, 0);
        chk("dn.q", 32'(q), 0);
        cyc(0, 1, 1, 0, 0);
        chk("dn.c1", 32'(count), 1);
        cyc(0, 1, 1, 0, 0);
        chk("dn.c0", 32'(count), 0);
        cyc(0, 1, 1, 0, 0);
        chk("dn.c3", 32'(count), SAT ? 0 : 99);
        chk("dn.q3", 32'(q), SAT ? 3 : 0);
        pulse_reset("rst_b");

        // Add once while l is held, then a second add.
        up_to(10);
        cyc(0, 0, 0, 0, 1);
        chk("add.stop_q", 32'(q), 3);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 1);
        chk("add.held", 32'(count), 15);
        chk("add.held_q", 32'(q), 1);
        cyc(0, 0, 0, 0, 1);
        chk("add.stop15", 32'(count), 15);
        chk("add.stop15_q", 32'(q), 3);
        cyc(0, 0, 0, 1, 1);
        chk("add.second", 32'(count), 20);
        cyc(0, 0, 0, 0, 1);
        pulse_reset("rst_c");

        // Add across the top bound.
        up_to(97);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("addwrap", 32'(count), SAT ? 99 : 2);
        cyc(0, 0, 0, 0, 1);
        pulse_reset("rst_d");

        // Priority: l over s, clr over l, add over a coincident tick.
        up_to(3);
        cyc(0, 0, 1, 1, 1);
        chk("pri.add_q", 32'(q), 1);
        chk("pri.add_cnt", 32'(count), 8);
        cyc(1, 0, 1, 1, 1);
        chk("pri.clr_cnt", 32'(count), 0);
        chk("pri.clr_q", 32'(q), 1);
        up_to(40);
        cyc(0, 1, 1, 1, 1);
        chk("pri.tick_add", 32'(count), 45);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(31) == 0), $urandom_range(1) == 1, $urandom_range(3) != 0,
                ($urandom_range(7) == 0), $urandom_range(1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
